// File: rtl/adc_wave_capture.sv
// Multi-channel ADC waveform capture with a circular buffer, level/slope trigger and pre-trigger history.
// Readout is 2 cycles from rd_ch/rd_addr to rd_data; a capture runs arm -> fill -> armed -> post -> done.
// No backpressure: one sample per cycle; arm is ignored while busy. Define ADC_CAP_AUTO_TRIG_EN for a timeout trigger.
module adc_wave_capture #(
    parameter int NCH   = 2,
    parameter int DW    = 14,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
`ifdef ADC_CAP_AUTO_TRIG_EN
    ,
    parameter int AUTO_TIMEOUT = 1 << 20
`endif
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic [NCH*DW-1:0] adc_data,
    input  logic [CW-1:0]     trig_src,
    input  logic [DW-1:0]     trig_level,
    input  logic              trig_slope,
    input  logic [AW-1:0]     pretrig,
    input  logic              arm,
    output logic              busy,
    output logic              done,
    output logic [15:0]       wave_number,
`ifdef ADC_CAP_AUTO_TRIG_EN
    output logic              auto_trig,
`endif
    input  logic [CW-1:0]     rd_ch,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data
);

    localparam int NSEL = 1 << CW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [AW-1:0] PRE_MAX  = AW'(DEPTH - 2);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] pre_q;
    logic [CW-1:0] src_q;
    logic [DW-1:0] lvl_q;
    logic          slope_q;
    logic [DW-1:0] prev_q;
    logic          first_q;
    logic [AW-1:0] trig_ptr_q;
    logic [AW-1:0] start_ptr_q;
    logic [15:0]   wave_q;

    logic [CW-1:0] rd_ch_q;
    logic [AW-1:0] rd_ptr_q;
    logic [DW-1:0] rd_data_q;

    logic [DW-1:0] ch_data [NSEL];
    logic [DW-1:0] mem [NSEL][DEPTH];

    logic          wr_en;
    logic          arm_ok;
    logic [DW-1:0] cur_s;
    logic          rise_hit;
    logic          fall_hit;
    logic          edge_hit;
    logic          trig_hit;
    logic [AW-1:0] pre_eff;

    // Unused select codes (NCH not a power of two) read as zero.
    for (genvar c = 0; c < NSEL; c++) begin : g_ch
        if (c < NCH) begin : g_real
            assign ch_data[c] = adc_data[c*DW +: DW];
        end else begin : g_pad
            assign ch_data[c] = '0;
        end
    end

    assign wr_en   = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
    assign arm_ok  = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign pre_eff = (pretrig > PRE_MAX) ? PRE_MAX : pretrig;
    assign cur_s   = ch_data[src_q];

    assign rise_hit = (prev_q < lvl_q) && (cur_s >= lvl_q);
    assign fall_hit = (prev_q > lvl_q) && (cur_s <= lvl_q);

    // With no pre-trigger history the previous sample is not a genuine predecessor, so skip one cycle.
    assign edge_hit = (state_q == S_ARMED) && !(first_q && (pre_q == '0))
                      && (slope_q ? rise_hit : fall_hit);

`ifdef ADC_CAP_AUTO_TRIG_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);

    logic [TW-1:0] to_cnt_q;
    logic          auto_q;
    logic          timeout_hit;

    assign timeout_hit = (state_q == S_ARMED) && (to_cnt_q == TW'(AUTO_TIMEOUT - 1));
    assign trig_hit    = edge_hit || timeout_hit;
    assign auto_trig   = auto_q;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
            auto_q   <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == S_ARMED) ? to_cnt_q + TW'(1) : '0;
            if (arm_ok) begin
                auto_q <= 1'b0;
            end else if (timeout_hit && !edge_hit) begin
                auto_q <= 1'b1;
            end
        end
    end
`else
    assign trig_hit = edge_hit;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                if (cnt_q == pre_q) begin
                    state_d = S_ARMED;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_ARMED: begin
                if (trig_hit) begin
                    state_d = S_POST;
                    cnt_d   = LAST_IDX - pre_q;
                end
            end
            S_POST: begin
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wptr_q      <= '0;
            pre_q       <= '0;
            src_q       <= '0;
            lvl_q       <= '0;
            slope_q     <= 1'b0;
            prev_q      <= '0;
            first_q     <= 1'b0;
            trig_ptr_q  <= '0;
            start_ptr_q <= '0;
            wave_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= (state_q == S_FILL) && (state_d == S_ARMED);
            if (arm_ok) begin
                pre_q   <= pre_eff;
                src_q   <= trig_src;
                lvl_q   <= trig_level;
                slope_q <= trig_slope;
            end
            if (wr_en) begin
                wptr_q <= wptr_q + AW'(1);
                prev_q <= cur_s;
            end
            if ((state_q == S_ARMED) && trig_hit) begin
                trig_ptr_q <= wptr_q;
            end
            if ((state_q == S_POST) && (cnt_q == AW'(1))) begin
                start_ptr_q <= trig_ptr_q - pre_q;
                wave_q      <= wave_q + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            for (int c = 0; c < NCH; c++) begin
                mem[c][wptr_q] <= ch_data[c];
            end
        end
    end

    // Readout index is relative to the oldest sample of the frozen waveform.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ch_q   <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rd_ch_q   <= rd_ch;
            rd_ptr_q  <= start_ptr_q + rd_addr;
            rd_data_q <= mem[rd_ch_q][rd_ptr_q];
        end
    end

    assign busy        = wr_en;
    assign done        = (state_q == S_DONE);
    assign wave_number = wave_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_adc_wave_capture.sv
// Randomized bench for adc_wave_capture: a sample-history reference model predicts trigger point,
// done timing and readout values; readout expectations are queued and checked by a separate monitor.
module tb_adc_wave_capture;

    localparam int NCH   = 2;
    localparam int DW    = 14;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int CW    = 1;

    logic              sys_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH*DW-1:0] adc_data = '0;
    logic [CW-1:0]     trig_src = '0;
    logic [DW-1:0]     trig_level = '0;
    logic              trig_slope = 1'b0;
    logic [AW-1:0]     pretrig = '0;
    logic              arm = 1'b0;
    logic              busy;
    logic              done;
    logic [15:0]       wave_number;
    logic [CW-1:0]     rd_ch = '0;
    logic [AW-1:0]     rd_addr = '0;
    logic [DW-1:0]     rd_data;

    adc_wave_capture #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .adc_data(adc_data),
        .trig_src(trig_src), .trig_level(trig_level), .trig_slope(trig_slope),
        .pretrig(pretrig), .arm(arm), .busy(busy), .done(done),
        .wave_number(wave_number), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NCH*DW-1:0] hist[$];
    int  cyc = 0;
    int  mode = 0;
    int  t0 = 0;
    bit  cap = 0;
    bit  have_wave = 0;
    int  arm_e, mP, m_src, m_lvl, m_slope;
    int  trig_e = -1;
    int  done_e = 0;
    int  w_trig = 0;
    int  w_P = 0;
    int  exp_wave = 0;

    logic [DW-1:0] exp_q[$];
    bit            rd_req = 0;
    bit            use_const = 0;
    logic [DW-1:0] const_val = '0;
    logic [1:0]    pipe = '0;
    logic [DW-1:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] smp(input int e, input int ch);
        logic [NCH*DW-1:0] w;
        w = hist[e];
        return w[ch*DW +: DW];
    endfunction

    function automatic logic [NCH*DW-1:0] gen(input int e);
        logic [DW-1:0] v0;
        logic [DW-1:0] v1;
        v0 = DW'($urandom);
        v1 = DW'($urandom);
        case (mode)
            1: v0 = DW'(e - t0);
            2: v1 = (e < t0) ? 14'd9400 : 14'd6000;
            3: v0 = (((e >= t0 + 2) && (e < t0 + 10)) || (e >= t0 + 20)) ? 14'd5000 : 14'd0;
            default: ;
        endcase
        return {v1, v0};
    endfunction

    // One clock: drive a sample, advance the model at the edge, then check the status outputs.
    task automatic cycle();
        int e;
        logic [DW-1:0] p, c;
        logic [NCH*DW-1:0] w;
        e = cyc;
        w = gen(e);
        adc_data = w;
        hist.push_back(w);
        @(posedge sys_clk);
        cyc++;
        if (!reset_n) begin
            cap = 0; have_wave = 0; exp_wave = 0;
        end else begin
            if (rd_req)
                exp_q.push_back(use_const ? const_val : smp(w_trig - w_P + int'(rd_addr), int'(rd_ch)));
            if (arm && !cap) begin
                cap = 1; arm_e = e; trig_e = -1;
                mP = (int'(pretrig) > DEPTH - 2) ? DEPTH - 2 : int'(pretrig);
                m_src = int'(trig_src); m_lvl = int'(trig_level); m_slope = int'(trig_slope);
            end else if (cap && trig_e < 0 && e >= arm_e + mP + 2 + ((mP == 0) ? 1 : 0)) begin
                p = smp(e - 1, m_src);
                c = smp(e, m_src);
                if (m_slope != 0 ? (int'(p) < m_lvl && int'(c) >= m_lvl)
                                 : (int'(p) > m_lvl && int'(c) <= m_lvl)) begin
                    trig_e = e;
                    done_e = e + DEPTH - 1 - mP;
                end
            end
            if (cap && trig_e >= 0 && e == done_e) begin
                cap = 0; have_wave = 1;
                exp_wave = (exp_wave + 1) % 65536;
                w_trig = trig_e; w_P = mP;
            end
        end
        #1;
        chk("busy", 32'(busy), 32'(cap));
        chk("done", 32'(done), 32'(have_wave && !cap));
        chk("wave_number", 32'(wave_number), 32'(exp_wave));
    endtask

    always @(posedge sys_clk) pipe <= {pipe[0], rd_req};

    always @(negedge sys_clk) begin
        if (pipe[1]) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_data: got %0d with no expected entry", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(mon_exp));
            end
        end
    end

    task automatic rd(input int ch, input int addr);
        rd_ch = CW'(ch);
        rd_addr = AW'(addr);
        rd_req = 1;
        cycle();
        rd_req = 0;
    endtask

    task automatic rd_k(input int ch, input int addr, input int val);
        use_const = 1;
        const_val = DW'(val);
        rd(ch, addr);
        use_const = 0;
    endtask

    task automatic rd_rand(input int n);
        for (int i = 0; i < n; i++) rd($urandom_range(0, NCH - 1), $urandom_range(0, DEPTH - 1));
        repeat (3) cycle();
    endtask

    task automatic start(input int P, input int src, input int lvl, input int slope);
        pretrig = AW'(P); trig_src = CW'(src); trig_level = DW'(lvl); trig_slope = slope[0];
        arm = 1;
        cycle();
        arm = 0;
        // Config is latched at arm; later changes must have no effect.
        pretrig = AW'($urandom); trig_src = CW'($urandom); trig_level = DW'($urandom);
        trig_slope = 1'($urandom);
    endtask

    task automatic run_capture(input int P, input int src, input int lvl, input int slope, input bit spam);
        int budget;
        start(P, src, lvl, slope);
        budget = 0;
        while (cap && budget < 4 * DEPTH) begin
            arm = spam && (($urandom_range(0, 15) == 0) || (trig_e >= 0 && cyc == done_e));
            cycle();
            arm = 0;
            budget++;
        end
        if (cap) begin
            checks++; errors++;
            $display("FAIL capture_timeout: busy for %0d cycles, required completion", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        repeat (3) cycle();
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        reset_n = 1;
        repeat (2) cycle();

        // Rising ramp on ch0
        mode = 1; t0 = cyc;
        run_capture(100, 0, 500, 1, 0);
        rd_k(0, 100, 500);
        rd_k(0, 99, 499);
        rd_rand(8);
        chk("wave_after_ramp", 32'(wave_number), 32'd1);

        // Falling step on ch1
        mode = 2; t0 = cyc + 230;
        run_capture(200, 1, 7000, 0, 0);
        rd_k(1, 200, 6000);
        rd_k(1, 199, 9400);
        for (int a = 195; a < 206; a++) rd(0, a);
        repeat (3) cycle();

        // Zero pre-trigger: first armed cycle must not trigger
        mode = 3; t0 = cyc;
        run_capture(0, 0, 1000, 1, 0);
        rd_k(0, 0, 5000);
        rd_k(0, 8, 5000);
        rd(0, 1);
        rd(1, 0);
        rd_rand(4);

        // Pre-trigger above limit is clamped; arm pulses while busy are ignored
        mode = 0;
        run_capture(DEPTH - 1, 1, 8192, 1, 1);
        rd(1, DEPTH - 2);
        rd(1, DEPTH - 3);
        rd(1, DEPTH - 1);
        rd(0, 0);
        rd_rand(6);

        for (int i = 0; i < 4; i++) begin
            run_capture($urandom_range(0, DEPTH - 1), $urandom_range(0, NCH - 1),
                        $urandom_range(4000, 12000), $urandom_range(0, 1), 1);
            rd(m_src, w_P);
            rd_rand(10);
        end

        // Asynchronous reset in the post-trigger phase
        start(300, 0, 8000, 0);
        budget = 0;
        while (!(trig_e >= 0 && cyc > trig_e + 5) && budget < 4 * DEPTH) begin
            cycle();
            budget++;
        end
        chk("reached_post", 32'(busy), 32'd1);
        #3 reset_n = 0;
        #1;
        cap = 0; have_wave = 0; exp_wave = 0;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_wave", 32'(wave_number), 32'd0);
        chk("async_rd_data", 32'(rd_data), 32'd0);
        repeat (3) cycle();
        reset_n = 1;
        repeat (2) cycle();
        run_capture(50, 1, 6000, 1, 0);
        rd(1, 50);
        rd(1, 49);
        rd_rand(8);
        chk("wave_after_reset", 32'(wave_number), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
